// File: rtl/bp_be_late_wb_buffer_pkg.sv
// Writeback packet layout and configuration helpers shared by the late-writeback buffer and its bench.
package bp_be_late_wb_buffer_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg = 2'd0,
        e_bp_unicore_cfg = 2'd1
    } bp_params_e;

    localparam int unsigned reg_addr_width_gp = 5;
    localparam int unsigned dword_width_gp    = 64;
    localparam int unsigned fflags_width_gp   = 5;

    typedef struct packed {
        logic                         ird_w_v;
        logic                         frd_w_v;
        logic                         ptw_w_v;
        logic [reg_addr_width_gp-1:0] rd_addr;
        logic [dword_width_gp-1:0]    rd_data;
        logic                         fflags_w_v;
        logic [fflags_width_gp-1:0]   fflags;
    } bp_be_wb_pkt_s;

    function automatic int unsigned bp_be_wb_pkt_width(bp_params_e cfg);
        case (cfg)
            e_bp_unicore_cfg: return $bits(bp_be_wb_pkt_s);
            default:          return $bits(bp_be_wb_pkt_s);
        endcase
    endfunction

    // A legal packet targets exactly one destination file.
    function automatic logic wb_pkt_dest_legal(bp_be_wb_pkt_s pkt);
        return $onehot({pkt.ird_w_v, pkt.frd_w_v, pkt.ptw_w_v});
    endfunction

endpackage

// File: rtl/bp_be_late_wb_starve_counter.sv
// Counts cycles the buffer head waits unaccepted; saturates at limit_p and flags saturation.
module bp_be_late_wb_starve_counter #(
    parameter int unsigned limit_p = 8
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic clear_i,
    input  logic incr_i,
    output logic sat_o
);

    localparam int unsigned width_lp = $clog2(limit_p + 1);
    localparam logic [width_lp-1:0] limit_lp = width_lp'(limit_p);

    logic [width_lp-1:0] cnt_r;

    assign sat_o = (cnt_r == limit_lp);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_r <= '0;
        end else if (clear_i) begin
            cnt_r <= '0;
        end else if (incr_i && !sat_o) begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

endmodule

// File: rtl/bp_be_late_wb_buffer.sv
// In-order buffer of completed long-latency writebacks (memory and arithmetic ports) feeding the
// scheduler's late-writeback interface, with force on starvation or full.
module bp_be_late_wb_buffer
    import bp_be_late_wb_buffer_pkg::*;
#(
    parameter bp_params_e  bp_params_p    = e_bp_default_cfg,
    parameter int unsigned els_p          = 4,
    parameter int unsigned starve_limit_p = 8,
    localparam int unsigned wb_pkt_width_lp = bp_be_wb_pkt_width(bp_params_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,

    input  logic [wb_pkt_width_lp-1:0] mem_wb_pkt_i,
    input  logic                       mem_wb_v_i,
    output logic                       mem_wb_ready_and_o,

    input  logic [wb_pkt_width_lp-1:0] arith_wb_pkt_i,
    input  logic                       arith_wb_v_i,
    output logic                       arith_wb_ready_and_o,

    output logic [wb_pkt_width_lp-1:0] late_wb_pkt_o,
    output logic                       late_wb_v_o,
    output logic                       late_wb_force_o,
    input  logic                       late_wb_yumi_i
);

    localparam int unsigned ptr_width_lp = $clog2(els_p);
    localparam int unsigned cnt_width_lp = $clog2(els_p + 1);
    localparam logic [cnt_width_lp-1:0] full_cnt_lp     = cnt_width_lp'(els_p);
    localparam logic [cnt_width_lp-1:0] mem_room_lp     = cnt_width_lp'(els_p - 1);
    localparam logic [cnt_width_lp-1:0] arith_room_lp   = cnt_width_lp'(els_p - 2);

    logic [wb_pkt_width_lp-1:0] mem_r [els_p];
    logic [ptr_width_lp-1:0]    rd_ptr_r, wr_ptr_r, arith_wr_ptr;
    logic [cnt_width_lp-1:0]    count_r;

    logic mem_ready, arith_ready, mem_xfer, arith_xfer;
    logic head_v, deq, starve_sat;
    logic [1:0] enq_n;

    assign mem_ready   = (count_r <= mem_room_lp);
    assign arith_ready = (count_r <= arith_room_lp);
    assign mem_xfer    = mem_wb_v_i & mem_ready;
    assign arith_xfer  = arith_wb_v_i & arith_ready;
    assign enq_n       = {1'b0, mem_xfer} + {1'b0, arith_xfer};

    assign head_v = (count_r != '0);
    assign deq    = late_wb_yumi_i & head_v;

    // A lone arith transfer takes the wr_ptr slot so the ring stays gap-free.
    assign arith_wr_ptr = wr_ptr_r + ptr_width_lp'(mem_xfer);

    always_ff @(posedge clk_i) begin
        if (mem_xfer) begin
            mem_r[wr_ptr_r] <= mem_wb_pkt_i;
        end
        if (arith_xfer) begin
            mem_r[arith_wr_ptr] <= arith_wb_pkt_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            rd_ptr_r <= rd_ptr_r + ptr_width_lp'(deq);
            wr_ptr_r <= wr_ptr_r + ptr_width_lp'(enq_n);
            count_r  <= count_r + cnt_width_lp'(enq_n) - cnt_width_lp'(deq);
        end
    end

    bp_be_late_wb_starve_counter #(
        .limit_p (starve_limit_p)
    ) starve_cnt (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (deq | ~head_v),
        .incr_i    (head_v),
        .sat_o     (starve_sat)
    );

    // Outputs are held at zero for the whole reset assertion, including the unreset head entry.
    assign mem_wb_ready_and_o   = reset_n_i & mem_ready;
    assign arith_wb_ready_and_o = reset_n_i & arith_ready;
    assign late_wb_v_o          = reset_n_i & head_v;
    assign late_wb_pkt_o        = reset_n_i ? mem_r[rd_ptr_r] : '0;
    assign late_wb_force_o      = reset_n_i & head_v & (starve_sat | (count_r == full_cnt_lp));

    yumi_without_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        late_wb_yumi_i |-> head_v);

    mem_pkt_dest: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        mem_xfer |-> wb_pkt_dest_legal(mem_wb_pkt_i));

    arith_pkt_dest: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        arith_xfer |-> wb_pkt_dest_legal(arith_wb_pkt_i));

endmodule

// File: tb/tb_bp_be_late_wb_buffer.sv
// Randomized and directed bench for bp_be_late_wb_buffer against a queue-based reference model.
module tb_bp_be_late_wb_buffer;
    import bp_be_late_wb_buffer_pkg::*;

    localparam int unsigned ELS   = 4;
    localparam int unsigned LIMIT = 8;
    localparam int unsigned W     = bp_be_wb_pkt_width(e_bp_default_cfg);

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic [W-1:0] mem_wb_pkt_i, arith_wb_pkt_i, late_wb_pkt_o;
    logic         mem_wb_v_i, arith_wb_v_i, late_wb_yumi_i;
    logic         mem_wb_ready_and_o, arith_wb_ready_and_o, late_wb_v_o, late_wb_force_o;

    always #5 clk_i = ~clk_i;

    bp_be_late_wb_buffer #(
        .bp_params_p    (e_bp_default_cfg),
        .els_p          (ELS),
        .starve_limit_p (LIMIT)
    ) dut (
        .clk_i                (clk_i),
        .reset_n_i            (reset_n_i),
        .mem_wb_pkt_i         (mem_wb_pkt_i),
        .mem_wb_v_i           (mem_wb_v_i),
        .mem_wb_ready_and_o   (mem_wb_ready_and_o),
        .arith_wb_pkt_i       (arith_wb_pkt_i),
        .arith_wb_v_i         (arith_wb_v_i),
        .arith_wb_ready_and_o (arith_wb_ready_and_o),
        .late_wb_pkt_o        (late_wb_pkt_o),
        .late_wb_v_o          (late_wb_v_o),
        .late_wb_force_o      (late_wb_force_o),
        .late_wb_yumi_i       (late_wb_yumi_i)
    );

    // Reference model: FIFO contents plus cycles the current head has waited.
    logic [W-1:0] q[$];
    int unsigned  starve;
    int unsigned  n_enq;
    int unsigned  pkt_id;
    int unsigned  n_checks, n_fail;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic model_force();
        return (q.size() != 0) && (starve == LIMIT || q.size() == ELS);
    endfunction

    function automatic logic [W-1:0] make_pkt();
        bp_be_wb_pkt_s p;
        int unsigned   sel;
        p = '0;
        sel = $urandom_range(0, 2);
        p.ird_w_v    = (sel == 0);
        p.frd_w_v    = (sel == 1);
        p.ptw_w_v    = (sel == 2);
        p.rd_addr    = 5'($urandom);
        p.rd_data    = {pkt_id, $urandom};
        p.fflags_w_v = 1'($urandom);
        p.fflags     = 5'($urandom);
        pkt_id++;
        return p;
    endfunction

    task automatic check_outputs();
        logic exp_v;
        exp_v = (q.size() != 0);
        check_eq("late_wb_v", late_wb_v_o, exp_v);
        check_eq("late_wb_force", late_wb_force_o, model_force());
        check_eq("mem_ready", mem_wb_ready_and_o, q.size() <= ELS - 1);
        check_eq("arith_ready", arith_wb_ready_and_o, q.size() <= ELS - 2);
        if (exp_v) check_eq("late_wb_pkt", late_wb_pkt_o, q[0]);
    endtask

    // One clock: check outputs, drive inputs, advance the model by the specified rules.
    task automatic step(input logic mv, input logic [W-1:0] mp,
                        input logic av, input logic [W-1:0] ap, input logic yumi_req);
        int unsigned sz;
        logic deq, mx, ax;
        check_outputs();
        sz  = q.size();
        deq = yumi_req && (sz != 0);
        mx  = mv && (sz <= ELS - 1);
        ax  = av && (sz <= ELS - 2);
        mem_wb_v_i     = mv;
        mem_wb_pkt_i   = mp;
        arith_wb_v_i   = av;
        arith_wb_pkt_i = ap;
        late_wb_yumi_i = deq;
        @(posedge clk_i);
        if (deq || sz == 0) starve = 0;
        else if (starve < LIMIT) starve++;
        if (deq) void'(q.pop_front());
        if (mx) begin q.push_back(mp); n_enq++; end
        if (ax) begin q.push_back(ap); n_enq++; end
        #1;
    endtask

    task automatic idle_inputs();
        mem_wb_v_i     = 1'b0;
        arith_wb_v_i   = 1'b0;
        late_wb_yumi_i = 1'b0;
        mem_wb_pkt_i   = '0;
        arith_wb_pkt_i = '0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && q.size() != 0; i++) step(1'b0, '0, 1'b0, '0, 1'b1);
        if (q.size() != 0) check_eq(tag, q.size(), 0);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; n_enq = 0; pkt_id = 1; starve = 0;
        idle_inputs();
        reset_n_i = 1'b0;
        #12;
        check_eq("reset_v", late_wb_v_o, 1'b0);
        check_eq("reset_mem_ready", mem_wb_ready_and_o, 1'b0);
        check_eq("reset_arith_ready", arith_wb_ready_and_o, 1'b0);
        reset_n_i = 1'b1;
        @(posedge clk_i); #1;

        // Single fill/drain on port 0 with yumi held.
        for (int i = 0; i < 3; i++) step(1'b1, make_pkt(), 1'b0, '0, 1'b1);
        drain("fill_drain_budget");
        check_outputs();

        // Dual enqueue from empty; mem packet must drain first.
        step(1'b1, make_pkt(), 1'b1, make_pkt(), 1'b0);
        drain("dual_drain_budget");

        // Dual enqueue at count 3: only the mem port is accepted, buffer goes full.
        for (int i = 0; i < 3; i++) step(1'b1, make_pkt(), 1'b0, '0, 1'b0);
        step(1'b1, make_pkt(), 1'b1, make_pkt(), 1'b0);
        check_eq("full_force", late_wb_force_o, 1'b1);
        check_eq("full_mem_ready", mem_wb_ready_and_o, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b1);
        // Enqueue with dequeue at count 3 keeps occupancy.
        step(1'b1, make_pkt(), 1'b0, '0, 1'b1);
        drain("full_drain_budget");

        // Starvation: single entry left waiting until force, then accepted.
        step(1'b1, make_pkt(), 1'b0, '0, 1'b0);
        for (int i = 0; i < 20 && !model_force(); i++) step(1'b0, '0, 1'b0, '0, 1'b0);
        check_eq("starve_force", late_wb_force_o, 1'b1);
        step(1'b0, '0, 1'b0, '0, 1'b1);
        check_eq("starve_release", late_wb_force_o, 1'b0);

        // Reset mid-operation with 3 entries queued.
        for (int i = 0; i < 3; i++) step(1'b1, make_pkt(), 1'b0, '0, 1'b0);
        idle_inputs();
        #2 reset_n_i = 1'b0;
        #1;
        check_eq("midreset_v", late_wb_v_o, 1'b0);
        check_eq("midreset_force", late_wb_force_o, 1'b0);
        check_eq("midreset_pkt", late_wb_pkt_o, '0);
        check_eq("midreset_mem_ready", mem_wb_ready_and_o, 1'b0);
        check_eq("midreset_arith_ready", arith_wb_ready_and_o, 1'b0);
        @(posedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        q.delete();
        starve = 0;
        @(posedge clk_i); #1;
        check_outputs();

        // Random run: 500 packets through the ring, alternating low and high drain pressure.
        n_enq = 0;
        for (int cyc = 0; cyc < 20000 && n_enq < 500; cyc++) begin
            logic yr;
            int unsigned thr;
            thr = ((cyc / 64) % 2 == 1) ? 1 : 3;
            yr  = model_force() ? 1'b1 : ($urandom_range(0, 3) < thr);
            step($urandom_range(0, 3) != 0, make_pkt(), 1'($urandom), make_pkt(), yr);
        end
        if (n_enq < 500) check_eq("random_budget", n_enq, 500);
        drain("random_drain_budget");
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
